// File: rtl/dac_frame_sched.sv
// dac_frame_sched
//   Two-requester frame scheduler that time-shares one 8-bit serial DAC
//   interface between channel A and channel B. Each channel has a one-deep
//   holding register filled through a valid/ready handshake. A free-running
//   4-bit frame counter defines 16-cycle frames (setup 0..7, shift 8..15).
//   At the 7->8 edge one full holder is granted (round-robin or A-priority),
//   its sample is latched onto dac_din/dac_a and dac_scen goes low for the
//   shift phase.
//
// Ports
//   clk_4M            : clock, all state changes on its rising edge
//   rst_n             : asynchronous active-low reset
//   enable            : 1 allows new frame grants
//   a_valid/a_data    : channel-A sample offer
//   a_ready           : channel-A holder empty
//   b_valid/b_data    : channel-B sample offer
//   b_ready           : channel-B holder empty
//   dac_din           : sample driven to the DAC interface din
//   dac_a             : channel select to the DAC interface (1 = A, 0 = B)
//   dac_scen          : active-low frame enable to the DAC interface
//   frame_done        : one-cycle pulse while cnt = 0 after a transfer frame
module dac_frame_sched #(
  parameter logic [3:0] SCEN_SELECT_PRELOAD = 4'b0000,
  parameter logic       RR_EN               = 1'b1
) (
  input  logic       clk_4M,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic [7:0] dac_din,
  output logic       dac_a,
  output logic       dac_scen,
  output logic       frame_done
);

  logic [3:0] r_cnt;
  logic       r_a_full;
  logic       r_b_full;
  logic [7:0] r_a_data;
  logic [7:0] r_b_data;
  logic       r_xfer;
  logic       r_last_grant;  // 1 = A was granted last, 0 = B
  logic [7:0] r_din;
  logic       r_dac_a;
  logic       r_done;

  logic       w_decide;
  logic       w_frame_end;
  logic       w_cand_a;
  logic       w_cand_b;
  logic       w_grant_a;
  logic       w_grant_b;
  logic       w_acc_a;
  logic       w_acc_b;

  assign w_decide    = (r_cnt == 4'd7);
  assign w_frame_end = (r_cnt == 4'd15);
  assign w_cand_a    = r_a_full & enable;
  assign w_cand_b    = r_b_full & enable;
  assign w_acc_a     = a_valid & ~r_a_full;
  assign w_acc_b     = b_valid & ~r_b_full;

  // Arbitration only matters on the decision edge; with both channels
  // contending, round-robin grants the channel that did not win last time.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (w_decide) begin
      if (w_cand_a && w_cand_b) begin
        if (RR_EN) begin
          w_grant_a = ~r_last_grant;
          w_grant_b = r_last_grant;
        end else begin
          w_grant_a = 1'b1;
        end
      end else begin
        w_grant_a = w_cand_a;
        w_grant_b = w_cand_b;
      end
    end
  end

  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= SCEN_SELECT_PRELOAD;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Holders: a granted holder empties on the decision edge. A holder that is
  // empty cannot be granted, so grant and accept never collide on one channel.
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      r_a_full <= 1'b0;
      r_b_full <= 1'b0;
    end else begin
      if (w_grant_a)    r_a_full <= 1'b0;
      else if (w_acc_a) r_a_full <= 1'b1;
      if (w_grant_b)    r_b_full <= 1'b0;
      else if (w_acc_b) r_b_full <= 1'b1;
    end
  end

  // Holder data needs no reset: it is qualified by the full flags.
  always_ff @(posedge clk_4M) begin
    if (w_acc_a) r_a_data <= a_data;
    if (w_acc_b) r_b_data <= b_data;
  end

  // Frame control and DAC-side registers. dac_din/dac_a only move on a
  // grant, so they are stable across the whole shift phase.
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer       <= 1'b0;
      r_last_grant <= 1'b0;
      r_din        <= 8'h00;
      r_dac_a      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_frame_end & r_xfer;
      if (w_grant_a || w_grant_b) begin
        r_xfer       <= 1'b1;
        r_last_grant <= w_grant_a;
        r_dac_a      <= w_grant_a;
        r_din        <= w_grant_a ? r_a_data : r_b_data;
      end else if (w_frame_end) begin
        r_xfer <= 1'b0;
      end
    end
  end

  assign a_ready    = ~r_a_full;
  assign b_ready    = ~r_b_full;
  assign dac_din    = r_din;
  assign dac_a      = r_dac_a;
  // Combinational from reset-cleared r_xfer, so it rises as soon as rst_n falls.
  assign dac_scen   = ~(r_cnt[3] & r_xfer);
  assign frame_done = r_done;

endmodule
